// File: rtl/alu_mc_if.sv
// Request/response bundle for alu_mc: issue-side valid/ready with operands
// and opcode, writeback-side valid/ready with result and status flags.
interface alu_mc_if #(
  parameter int bitWidth = 32
);
  logic                valid_i;
  logic                ready_o;
  logic [bitWidth-1:0] rs1_data_i;
  logic [bitWidth-1:0] rs2_data_i;
  logic                Cin_i;
  logic [3:0]          cmd_i;
  logic                valid_o;
  logic                ready_i;
  logic [bitWidth-1:0] data_o;
  logic                carry_o;
  logic                illegal_o;

  // The ALU side.
  modport slave (
    input  valid_i, rs1_data_i, rs2_data_i, Cin_i, cmd_i, ready_i,
    output ready_o, valid_o, data_o, carry_o, illegal_o
  );

  // The issue/writeback side driving the ALU.
  modport master (
    output valid_i, rs1_data_i, rs2_data_i, Cin_i, cmd_i, ready_i,
    input  ready_o, valid_o, data_o, carry_o, illegal_o
  );
endinterface

// File: rtl/alu_mc.sv
// Registered multi-cycle integer ALU. Single-cycle ops load the output
// holding register at the accept edge; MUL/MULHU run an iterative shift-add
// multiplier and present the result once it is complete.
//
// state    | meaning
// IDLE     | accepting requests, output register may hold a result
// MUL_RUN  | one shift-add iteration per cycle, requests blocked
// MUL_DONE | load accumulator half into the output register
module alu_mc #(
  parameter int bitWidth = 32,
  parameter bit MUL_EN   = 1'b1
) (
  input logic   clk_i,
  input logic   rst_i,
  alu_mc_if.slave bus
);
  localparam int SHW = $clog2(bitWidth);
  localparam int CW  = SHW + 1;

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_AND   = 4'd1;
  localparam logic [3:0] OP_OR    = 4'd2;
  localparam logic [3:0] OP_XOR   = 4'd3;
  localparam logic [3:0] OP_SUB   = 4'd4;
  localparam logic [3:0] OP_SLL   = 4'd5;
  localparam logic [3:0] OP_SRL   = 4'd6;
  localparam logic [3:0] OP_SRA   = 4'd7;
  localparam logic [3:0] OP_SLT   = 4'd8;
  localparam logic [3:0] OP_SLTU  = 4'd9;
  localparam logic [3:0] OP_MUL   = 4'd10;
  localparam logic [3:0] OP_MULHU = 4'd11;

  localparam logic [bitWidth:0] ONE_X    = {{bitWidth{1'b0}}, 1'b1};
  localparam logic [CW-1:0]     CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]     CNT_LAST = bitWidth[CW-1:0];

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MUL_RUN  = 2'd1,
    MUL_DONE = 2'd2
  } state_t;

  state_t                  state;
  logic [2*bitWidth-1:0]   acc;
  logic [2*bitWidth-1:0]   mcand;
  logic [bitWidth-1:0]     mplier;
  logic [CW-1:0]           cnt;
  logic                    mul_hi;

  logic [bitWidth-1:0]     data_q;
  logic                    carry_q;
  logic                    illegal_q;
  logic                    valid_q;

  logic [bitWidth-1:0]     op_a;
  logic [bitWidth-1:0]     op_b;
  logic [SHW-1:0]          shamt;
  logic                    ready;
  logic                    accept;

  logic [bitWidth:0]       add_sum;
  logic [bitWidth:0]       sub_sum;
  logic [bitWidth-1:0]     res_data;
  logic                    res_carry;
  logic                    res_illegal;
  logic                    is_mul;

  assign op_a  = bus.rs1_data_i;
  assign op_b  = bus.rs2_data_i;
  assign shamt = op_b[SHW-1:0];

  // A new request is only taken in IDLE and only if the holding register
  // is empty or being drained this cycle, so a result is never overwritten.
  assign ready  = (state == IDLE) && (!valid_q || bus.ready_i) && !rst_i;
  assign accept = bus.valid_i && ready;

  assign bus.ready_o   = ready;
  assign bus.valid_o   = valid_q;
  assign bus.data_o    = data_q;
  assign bus.carry_o   = carry_q;
  assign bus.illegal_o = illegal_q;

  // Single-cycle result and opcode classification for the current request.
  always_comb begin
    add_sum     = {1'b0, op_a} + {1'b0, op_b} + {{bitWidth{1'b0}}, bus.Cin_i};
    // a + ~b + 1: the top bit is the not-borrow flag.
    sub_sum     = {1'b0, op_a} + {1'b0, ~op_b} + ONE_X;
    res_data    = '0;
    res_carry   = 1'b0;
    res_illegal = 1'b0;
    is_mul      = 1'b0;
    case (bus.cmd_i)
      OP_ADD: begin
        res_data  = add_sum[bitWidth-1:0];
        res_carry = add_sum[bitWidth];
      end
      OP_AND:  res_data = op_a & op_b;
      OP_OR:   res_data = op_a | op_b;
      OP_XOR:  res_data = op_a ^ op_b;
      OP_SUB: begin
        res_data  = sub_sum[bitWidth-1:0];
        res_carry = sub_sum[bitWidth];
      end
      OP_SLL:  res_data = op_a << shamt;
      OP_SRL:  res_data = op_a >> shamt;
      OP_SRA:  res_data = $unsigned($signed(op_a) >>> shamt);
      OP_SLT:  res_data = {{(bitWidth-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      OP_SLTU: res_data = {{(bitWidth-1){1'b0}}, (op_a < op_b)};
      OP_MUL, OP_MULHU: begin
        if (MUL_EN) is_mul = 1'b1;
        else        res_illegal = 1'b1;
      end
      default: res_illegal = 1'b1;
    endcase
  end

  // Control FSM, multiplier datapath and output holding register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      cnt       <= '0;
      mul_hi    <= 1'b0;
      data_q    <= '0;
      carry_q   <= 1'b0;
      illegal_q <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (is_mul) begin
              acc     <= '0;
              mcand   <= {{bitWidth{1'b0}}, op_a};
              mplier  <= op_b;
              cnt     <= '0;
              mul_hi  <= (bus.cmd_i == OP_MULHU);
              valid_q <= 1'b0;
              state   <= MUL_RUN;
            end else begin
              data_q    <= res_data;
              carry_q   <= res_carry;
              illegal_q <= res_illegal;
              valid_q   <= 1'b1;
            end
          end else if (bus.ready_i) begin
            valid_q <= 1'b0;
          end
        end
        MUL_RUN: begin
          // One extra cycle after the last iteration keeps the multiply
          // latency at bitWidth+2 edges from accept to valid_o.
          if (cnt == CNT_LAST) begin
            state <= MUL_DONE;
          end else begin
            if (mplier[0]) acc <= acc + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CNT_ONE;
          end
        end
        MUL_DONE: begin
          data_q    <= mul_hi ? acc[2*bitWidth-1:bitWidth] : acc[bitWidth-1:0];
          carry_q   <= 1'b0;
          illegal_q <= 1'b0;
          valid_q   <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_mc.sv
// Directed bench for alu_mc: expected results are queued at accept and
// checked in order as the DUT hands them over.
module tb_alu_mc;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_mc_if #(.bitWidth(32)) bus ();
  alu_mc_if #(.bitWidth(32)) bus_n ();

  alu_mc #(.bitWidth(32), .MUL_EN(1'b1)) dut (
    .clk_i(clk), .rst_i(rst), .bus(bus.slave)
  );
  alu_mc #(.bitWidth(32), .MUL_EN(1'b0)) dut_n (
    .clk_i(clk), .rst_i(rst), .bus(bus_n.slave)
  );

  typedef struct packed {
    logic [31:0] d;
    logic        c;
    logic        il;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  exp_t tmp_e;
  int   vectors     = 0;
  int   miscompares = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference for the add/logic/sub group using wide arithmetic.
  function automatic exp_t model(input logic [3:0] cmd, input logic [31:0] a,
                                 input logic [31:0] b, input logic cin);
    logic [63:0] w;
    exp_t e;
    e = '0;
    w = '0;
    case (cmd)
      4'd0: begin
        w    = {32'd0, a} + {32'd0, b} + {63'd0, cin};
        e.d  = w[31:0];
        e.c  = w[32];
      end
      4'd1: e.d = a & b;
      4'd2: e.d = a | b;
      4'd3: e.d = a ^ b;
      4'd4: begin
        e.d = a - b;
        e.c = (a >= b);
      end
      default: e.il = 1'b1;
    endcase
    return e;
  endfunction

  // Scoreboard: every handed-over result must match the oldest expectation.
  always @(negedge clk) begin
    if (!rst && bus.valid_o === 1'b1 && bus.ready_i === 1'b1) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $error("FAIL unexpected_result: observed %h expected none", bus.data_o);
      end else begin
        mon_e = sb.pop_front();
        check("result", 64'({bus.data_o, bus.carry_o, bus.illegal_o}), 64'(mon_e));
      end
    end
  end

  // Drive one request starting just after a posedge; returns just after the accept edge.
  task automatic issue(input logic [3:0] cmd, input logic [31:0] a, input logic [31:0] b,
                       input logic cin, input exp_t e);
    bus.cmd_i      = cmd;
    bus.rs1_data_i = a;
    bus.rs2_data_i = b;
    bus.Cin_i      = cin;
    bus.valid_i    = 1'b1;
    @(negedge clk);
    check("ready_o_at_issue", 64'(bus.ready_o), 64'(1));
    @(posedge clk);
    sb.push_back(e);
    #1;
    bus.valid_i = 1'b0;
  endtask

  task automatic lat1(input string tag);
    @(negedge clk);
    check(tag, 64'(bus.valid_o), 64'(1));
    @(posedge clk);
    #1;
  endtask

  task automatic mul_wait();
    int n;
    bit done;
    n    = 0;
    done = 1'b0;
    while (!done && n < 80) begin
      @(negedge clk);
      n++;
      if (bus.valid_o === 1'b1) done = 1'b1;
      else check("ready_o_mul_run", 64'(bus.ready_o), 64'(0));
    end
    check("mul_latency", 64'(n - 1), 64'(34));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ra, rb;
    logic        rc;
    bit          seen;

    bus.valid_i = 1'b0; bus.ready_i = 1'b1; bus.cmd_i = 4'd0;
    bus.rs1_data_i = '0; bus.rs2_data_i = '0; bus.Cin_i = 1'b0;
    bus_n.valid_i = 1'b0; bus_n.ready_i = 1'b1; bus_n.cmd_i = 4'd0;
    bus_n.rs1_data_i = '0; bus_n.rs2_data_i = '0; bus_n.Cin_i = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid_o",   64'(bus.valid_o),   64'(0));
    check("rst_data_o",    64'(bus.data_o),    64'(0));
    check("rst_carry_o",   64'(bus.carry_o),   64'(0));
    check("rst_illegal_o", 64'(bus.illegal_o), 64'(0));
    check("rst_ready_o",   64'(bus.ready_o),   64'(0));
    @(posedge clk); #1;
    rst = 1'b0;

    issue(4'd0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, '{32'h0000_0000, 1'b1, 1'b0});
    lat1("add_wrap_latency");
    issue(4'd0, 32'd5, 32'd3, 1'b1, '{32'd9, 1'b0, 1'b0});
    lat1("add_cin_latency");

    // Back-to-back issue, results stream out in order one per cycle.
    issue(4'd4, 32'd3, 32'd5, 1'b0, '{32'hFFFF_FFFE, 1'b0, 1'b0});
    issue(4'd7, 32'h8000_0000, 32'd4, 1'b0, '{32'hF800_0000, 1'b0, 1'b0});
    issue(4'd6, 32'h8000_0000, 32'd4, 1'b0, '{32'h0800_0000, 1'b0, 1'b0});
    issue(4'd8, 32'hFFFF_FFFF, 32'd1, 1'b0, '{32'd1, 1'b0, 1'b0});
    issue(4'd9, 32'hFFFF_FFFF, 32'd1, 1'b0, '{32'd0, 1'b0, 1'b0});
    issue(4'd5, 32'h0000_0003, 32'd31, 1'b0, '{32'h8000_0000, 1'b0, 1'b0});
    issue(4'd4, 32'd7, 32'd7, 1'b0, '{32'd0, 1'b1, 1'b0});
    for (int i = 0; i < 10; i++) begin
      ra = $urandom;
      rb = $urandom;
      rc = 1'($urandom_range(0, 1));
      issue(4'(i % 5), ra, rb, rc, model(4'(i % 5), ra, rb, rc));
    end
    lat1("stream_tail_valid");

    // Backpressure: held result stays put and a pending request waits.
    issue(4'd3, 32'hA5A5_A5A5, 32'h0F0F_0F0F, 1'b0, '{32'hAAAA_AAAA, 1'b0, 1'b0});
    bus.ready_i    = 1'b0;
    bus.cmd_i      = 4'd0;
    bus.rs1_data_i = 32'd2;
    bus.rs2_data_i = 32'd3;
    bus.Cin_i      = 1'b0;
    bus.valid_i    = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("hold_valid_o", 64'(bus.valid_o), 64'(1));
      check("hold_data_o",  64'(bus.data_o),  64'(32'hAAAA_AAAA));
      check("hold_ready_o", 64'(bus.ready_o), 64'(0));
    end
    @(posedge clk); #1;
    bus.ready_i = 1'b1;
    @(negedge clk);
    check("release_ready_o", 64'(bus.ready_o), 64'(1));
    @(posedge clk);
    sb.push_back('{32'd5, 1'b0, 1'b0});
    #1;
    bus.valid_i = 1'b0;
    lat1("release_latency");

    issue(4'd10, 32'h0001_0000, 32'h0001_0000, 1'b0, '{32'h0000_0000, 1'b0, 1'b0});
    mul_wait();
    issue(4'd11, 32'h0001_0000, 32'h0001_0000, 1'b0, '{32'h0000_0001, 1'b0, 1'b0});
    mul_wait();
    issue(4'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, '{32'h0000_0001, 1'b0, 1'b0});
    mul_wait();
    issue(4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, '{32'hFFFF_FFFE, 1'b0, 1'b0});
    mul_wait();

    issue(4'd13, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1, '{32'h0000_0000, 1'b0, 1'b1});
    lat1("illegal_latency");

    bus_n.cmd_i      = 4'd10;
    bus_n.rs1_data_i = 32'h0000_0003;
    bus_n.rs2_data_i = 32'h0000_0005;
    bus_n.valid_i    = 1'b1;
    @(negedge clk);
    check("nomul_ready_o", 64'(bus_n.ready_o), 64'(1));
    @(posedge clk); #1;
    bus_n.valid_i = 1'b0;
    @(negedge clk);
    check("nomul_valid_o",   64'(bus_n.valid_o),   64'(1));
    check("nomul_illegal_o", 64'(bus_n.illegal_o), 64'(1));
    check("nomul_data_o",    64'(bus_n.data_o),    64'(0));
    check("nomul_carry_o",   64'(bus_n.carry_o),   64'(0));
    @(posedge clk); #1;

    // Reset in the middle of a multiply discards it.
    issue(4'd10, 32'h0000_1234, 32'h0000_5678, 1'b0, '{32'h0626_0060, 1'b0, 1'b0});
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    tmp_e = sb.pop_back();
    @(negedge clk);
    check("midrst_ready_o", 64'(bus.ready_o), 64'(0));
    check("midrst_valid_o", 64'(bus.valid_o), 64'(0));
    @(posedge clk); #1;
    rst  = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (bus.valid_o === 1'b1) seen = 1'b1;
    end
    check("midrst_no_result", 64'(seen), 64'(0));
    @(posedge clk); #1;
    issue(4'd0, 32'd2, 32'd2, 1'b0, '{32'd4, 1'b0, 1'b0});
    lat1("post_rst_latency");

    @(negedge clk);
    check("scoreboard_empty", 64'(sb.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
- Registered, multi-cycle successor to the single-cycle 2-bit-command integer ALU.
- Widens the opcode to 4 bits and keeps the legacy ADD/AND/OR/XOR encodings.
- Adds SUB, shifts, compares and an iterative shift-add multiplier.
- Sits between issue and writeback behind a valid/ready handshake on both sides, with one output holding register.

Parameters:
bitWidth, 32, datapath width in bits (>=8, power of 2)
MUL_EN, 1, 1 = MUL/MULHU implemented; 0 = those opcodes are illegal

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
valid_i  in  1  operation request
ready_o  out  1  block accepts request this cycle
rs1_data_i  in  bitWidth  operand A
rs2_data_i  in  bitWidth  operand B
Cin_i  in  1  carry-in (ADD only)
cmd_i  in  4  opcode
valid_o  out  1  result valid
ready_i  in  1  downstream accepts result
data_o  out  bitWidth  result
carry_o  out  1  carry-out (ADD) / not-borrow (SUB); 0 otherwise
illegal_o  out  1  opcode was unsupported

Behaviour:
- Reset values: valid_o=0, data_o=0, carry_o=0, illegal_o=0, FSM=IDLE, counter=0. ready_o=0 while rst_i=1.
- Handshake:
  - Accept = valid_i & ready_o at a rising edge; operands and cmd are captured at that edge.
  - ready_o = (state==IDLE) & (!valid_o | ready_i).
  - Result transfer = valid_o & ready_i.
  - While valid_o=1 & ready_i=0, data_o, carry_o and illegal_o are held stable.
- Opcodes (shamt = rs2[log2(bitWidth)-1:0]):
  - 0 ADD rs1+rs2+Cin; 1 AND; 2 OR; 3 XOR
  - 4 SUB rs1-rs2
  - 5 SLL; 6 SRL; 7 SRA (arithmetic)
  - 8 SLT signed, result 1/0; 9 SLTU unsigned, result 1/0
  - 10 MUL: low bitWidth bits of rs1*rs2
  - 11 MULHU: high bitWidth bits of unsigned rs1*rs2
  - 12-15, or 10/11 with MUL_EN=0: data_o=0, carry_o=0, illegal_o=1, single-cycle timing.
- Arithmetic: all results wrap modulo 2^bitWidth.
  - carry_o = bit bitWidth of the (bitWidth+1)-bit sum for ADD.
  - For SUB, carry_o = 1 iff rs1>=rs2 unsigned.
- FSM states:
  - IDLE: on accept of a non-multiply op, the output register loads its result at the same edge. valid_o=1 next cycle (latency 1, throughput 1/cycle). On accept of MUL/MULHU, clear the 2*bitWidth accumulator, load the multiplicand/multiplier, set counter=0, and go to MUL_RUN.
  - MUL_RUN: ready_o=0. Each cycle, if the multiplier LSB is set, add the multiplicand (shifted) to the accumulator. Shift the multiplier right and increment the counter. After bitWidth iterations go to MUL_DONE.
  - MUL_DONE: load the output register with accumulator low (MUL) or high (MULHU), carry_o=0, illegal_o=0, valid_o=1. Return to IDLE.
  - Multiply latency: valid_o rises bitWidth+2 cycles after the accept edge.
- Back-to-back: in IDLE with valid_o=1, ready_i=1 and valid_i=1, the new result replaces the old one and valid_o stays 1.
- Multiply accepted while the previous result transfers: valid_o drops next cycle and stays 0 until MUL_DONE.
- Output register is always empty when MUL_DONE loads, because ready_o gates acceptance. No overwrite case exists.
- Reset mid-multiply: the FSM returns to IDLE, the result is discarded, valid_o=0, and no partial result is ever presented.
- valid_i while ready_o=0: ignored. Operands are not captured, and the requester must hold them.

Test Plan:
- Reset, then ADD 0xFFFFFFFF+0x00000001 Cin=0 -> next cycle valid_o=1, data_o=0x00000000, carry_o=1. Separately, ADD 5+3 Cin=1 -> 9, carry_o=0.
- SUB 3-5 -> 0xFFFFFFFE, carry_o=0. SRA 0x80000000 by 4 -> 0xF8000000. SRL same -> 0x08000000. SLT 0xFFFFFFFF,1 -> 1. SLTU same -> 0. All legacy opcodes 0-3 match their prior results.
- Issue 4 ops on consecutive cycles with ready_i=1 -> 4 results on consecutive cycles, in order. Then hold ready_i=0 for 3 cycles -> data_o stable, ready_o=0, a pending valid_i is not accepted.
- MUL 0x0001_0000*0x0001_0000 -> 0x00000000 after 34 cycles. MULHU same -> 0x00000001. MUL 0xFFFFFFFF*0xFFFFFFFF -> 0x00000001. ready_o=0 throughout the run.
- cmd=13, and cmd=10 with MUL_EN=0 -> illegal_o=1, data_o=0, latency 1.
- Assert rst_i 10 cycles into a MUL -> valid_o never rises. The next ADD 2+2 is accepted and returns 4 at latency 1.
